// File: rtl/btn_pulse_ctrl_pkg.sv
// Shared types and board-clock timing defaults for the front-panel button controller.
package btn_pulse_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } btn_st_e;

  // 24 MHz board clock: 10 ms debounce, 1 s long press
  localparam int DEF_NUM_BTN  = 2;
  localparam int DEF_DEB_CYC  = 240000;
  localparam int DEF_LONG_CYC = 24000000;

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-FF synchronizer, debounce counter, press classifier FSM.
// BTN_PULSE_CTRL_LONG_EN enables long-press detection; otherwise a short pulse fires on press.
module btn_chan
  import btn_pulse_ctrl_pkg::*;
#(
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic i_btn_n,
  output logic o_btn_lvl,
  output logic o_short_pls,
  output logic o_long_pls
);

  localparam int              DW      = $clog2(DEB_CYC);
  localparam logic [DW-1:0]   DEB_MAX = DW'(DEB_CYC - 1);

  if (DEB_CYC < 2 || LONG_CYC <= DEB_CYC) begin : g_cfg_err
    $error("btn_chan: need DEB_CYC >= 2 and LONG_CYC > DEB_CYC");
  end

  logic [1:0]    sync_q;
  logic [DW-1:0] deb_q, deb_d;
  logic          lvl_q, lvl_d;
  btn_st_e       st_q, st_d;
  logic          short_q, short_d;
  logic          long_q, long_d;

  always_comb begin
    deb_d = '0;
    lvl_d = lvl_q;
    if (sync_q[1] != lvl_q) begin
      if (deb_q == DEB_MAX) lvl_d = ~lvl_q;
      else                  deb_d = deb_q + 1'b1;
    end
  end

`ifdef BTN_PULSE_CTRL_LONG_EN
  localparam int            HW       = $clog2(LONG_CYC);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYC - 2);

  logic [HW-1:0] hold_q, hold_d;

  // Long fires on the edge where hold reaches LONG_CYC-1, i.e. LONG_CYC cycles after the level rise;
  // a release seen on that same edge takes priority.
  always_comb begin
    st_d    = st_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    hold_d  = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    case (st_q)
      ST_IDLE: begin
        hold_d = '0;
        if (lvl_q) st_d = ST_PRESS;
      end
      ST_PRESS: begin
        if (!lvl_q) begin
          st_d    = ST_IDLE;
          short_d = 1'b1;
        end else if (hold_q == HOLD_PRE) begin
          st_d   = ST_HELD;
          long_d = 1'b1;
        end
      end
      ST_HELD: if (!lvl_q) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) hold_q <= '0;
    else          hold_q <= hold_d;
  end
`else
  always_comb begin
    st_d    = st_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (lvl_q) begin
          st_d    = ST_PRESS;
          short_d = 1'b1;
        end
      end
      default: if (!lvl_q) st_d = ST_IDLE;
    endcase
  end
`endif

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      sync_q  <= '0;
      deb_q   <= '0;
      lvl_q   <= 1'b0;
      st_q    <= ST_IDLE;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], ~i_btn_n};
      deb_q   <= deb_d;
      lvl_q   <= lvl_d;
      st_q    <= st_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign o_btn_lvl   = lvl_q;
  assign o_short_pls = short_q;
  assign o_long_pls  = long_q;

endmodule

// File: rtl/btn_pulse_ctrl.sv
// Front-panel button controller: NUM_BTN independent debounced channels with short/long pulses.
// Long-press detection is built only with BTN_PULSE_CTRL_LONG_EN defined.
module btn_pulse_ctrl
  import btn_pulse_ctrl_pkg::*;
#(
  parameter int NUM_BTN  = DEF_NUM_BTN,
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC
) (
  input  logic               i_clk,
  input  logic               i_res_n,
  input  logic [NUM_BTN-1:0] i_btn_n,
  output logic [NUM_BTN-1:0] o_btn_lvl,
  output logic [NUM_BTN-1:0] o_short_pls,
  output logic [NUM_BTN-1:0] o_long_pls
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_chan #(
      .DEB_CYC  (DEB_CYC),
      .LONG_CYC (LONG_CYC)
    ) u_chan (
      .i_clk       (i_clk),
      .i_res_n     (i_res_n),
      .i_btn_n     (i_btn_n[g]),
      .o_btn_lvl   (o_btn_lvl[g]),
      .o_short_pls (o_short_pls[g]),
      .o_long_pls  (o_long_pls[g])
    );
  end

endmodule

// File: tb/tb_btn_pulse_ctrl.sv
// Directed bench for btn_pulse_ctrl with DEB_CYC=4, LONG_CYC=16; expectations follow BTN_PULSE_CTRL_LONG_EN.
module tb_btn_pulse_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_n;
  logic [1:0] o_btn_lvl, o_short_pls, o_long_pls;

  int n_tests = 0;
  int n_fail  = 0;

  btn_pulse_ctrl #(.NUM_BTN(2), .DEB_CYC(4), .LONG_CYC(16)) dut (
    .i_clk       (clk),
    .i_res_n     (rst_n),
    .i_btn_n     (btn_n),
    .o_btn_lvl   (o_btn_lvl),
    .o_short_pls (o_short_pls),
    .o_long_pls  (o_long_pls)
  );

  always #5 clk = ~clk;

  // Times are negedges after the press was applied; -1 means the event must not occur.
  typedef struct packed {
    logic [1:0] mask;
    int         len;
    int         rise;
    int         fall;
    int         sh;
    int         lg;
  } vec_t;

  vec_t tbl [8];

  function automatic vec_t mk(input logic [1:0] m, input int len, input int rise,
                              input int fall, input int sh, input int lg);
    vec_t v;
    v.mask = m; v.len = len; v.rise = rise; v.fall = fall; v.sh = sh; v.lg = lg;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int rise [2];
    int fall [2];
    int sh   [2];
    int lg   [2];
    int ns   [2];
    int nl   [2];
    for (int c = 0; c < 2; c++) begin
      rise[c] = -1; fall[c] = -1; sh[c] = -1; lg[c] = -1; ns[c] = 0; nl[c] = 0;
    end
    for (int t = 0; t < v.len + 40; t++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (o_btn_lvl[c] && rise[c] < 0) rise[c] = t;
        if (!o_btn_lvl[c] && rise[c] >= 0 && fall[c] < 0) fall[c] = t;
        if (o_short_pls[c]) begin ns[c]++; if (sh[c] < 0) sh[c] = t; end
        if (o_long_pls[c])  begin nl[c]++; if (lg[c] < 0) lg[c] = t; end
      end
      btn_n = (t < v.len) ? ~v.mask : 2'b11;
    end
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("v%0d ch%0d rise", idx, c), rise[c], v.mask[c] ? v.rise : -1);
      chk($sformatf("v%0d ch%0d fall", idx, c), fall[c], v.mask[c] ? v.fall : -1);
      chk($sformatf("v%0d ch%0d short_t", idx, c), sh[c], v.mask[c] ? v.sh : -1);
      chk($sformatf("v%0d ch%0d long_t", idx, c), lg[c], v.mask[c] ? v.lg : -1);
      chk($sformatf("v%0d ch%0d short_n", idx, c), ns[c], (v.mask[c] && v.sh >= 0) ? 1 : 0);
      chk($sformatf("v%0d ch%0d long_n", idx, c), nl[c], (v.mask[c] && v.lg >= 0) ? 1 : 0);
    end
  endtask

  initial begin
    int npls;
    // press at negedge 0 -> level at 6 (2 sync + 4 debounce), level high for len cycles
`ifdef BTN_PULSE_CTRL_LONG_EN
    tbl[0] = mk(2'b01,  3, -1, -1, -1, -1);  // glitch
    tbl[1] = mk(2'b01, 10,  6, 16, 17, -1);  // short press
    tbl[2] = mk(2'b10, 40,  6, 46, -1, 22);  // long press
    tbl[3] = mk(2'b11, 10,  6, 16, 17, -1);  // simultaneous
    tbl[4] = mk(2'b01, 15,  6, 21, 22, -1);  // release on the threshold edge: short wins
    tbl[5] = mk(2'b10, 16,  6, 22, -1, 22);  // minimum long press
    tbl[6] = mk(2'b01,  4,  6, 10, 11, -1);  // exactly DEB_CYC stable
    tbl[7] = mk(2'b11, 40,  6, 46, -1, 22);  // simultaneous long
`else
    tbl[0] = mk(2'b01,  3, -1, -1, -1, -1);
    tbl[1] = mk(2'b01, 10,  6, 16,  7, -1);
    tbl[2] = mk(2'b10, 40,  6, 46,  7, -1);
    tbl[3] = mk(2'b11, 10,  6, 16,  7, -1);
    tbl[4] = mk(2'b01, 15,  6, 21,  7, -1);
    tbl[5] = mk(2'b10, 16,  6, 22,  7, -1);
    tbl[6] = mk(2'b01,  4,  6, 10,  7, -1);
    tbl[7] = mk(2'b11, 40,  6, 46,  7, -1);
`endif

    // reset with both buttons held
    rst_n = 1'b0;
    btn_n = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst lvl", int'(o_btn_lvl), 0);
    chk("rst short", int'(o_short_pls), 0);
    chk("rst long", int'(o_long_pls), 0);
    rst_n = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (t == 5) chk("post-rst lvl t5", int'(o_btn_lvl), 0);
      if (t == 6) chk("post-rst lvl t6", int'(o_btn_lvl), 3);
    end
    btn_n = 2'b11;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    // reset mid-press at hold cycle 8
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      btn_n = 2'b00;
    end
    @(negedge clk);
    chk("mid lvl before rst", int'(o_btn_lvl), 3);
    rst_n = 1'b0;
    btn_n = 2'b11;
    #1;
    chk("mid rst lvl", int'(o_btn_lvl), 0);
    chk("mid rst pulses", int'({o_short_pls, o_long_pls}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    npls = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      npls += int'(o_short_pls[0]) + int'(o_short_pls[1]) + int'(o_long_pls[0]) + int'(o_long_pls[1]);
      npls += int'(o_btn_lvl[0]) + int'(o_btn_lvl[1]);
    end
    chk("after mid rst activity", npls, 0);
    run_vec(8, tbl[3]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
